max_diff_seq: RTL and testbench
===============================

MAX_DIFF_SEQ -- requirements
Module: max_diff_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have ports x, y, z, input, WIDTH each, unsigned operands sampled at input handshake.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream offers x/y/z.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept an operand set.
REQ-007 The block SHALL have port o, output, WIDTH, the maximum pairwise absolute difference.
REQ-008 The block SHALL have port o_pair, output, 2, the pair giving o: 0=x/y, 1=x/z, 2=y/z; 3 is never driven.
REQ-009 The block SHALL have port out_valid, output, 1, meaning o/o_pair hold a result.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, CMP0 (x/y), CMP1 (x/z), CMP2 (y/z) and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE with in_valid=1, the block SHALL latch x, y and z into internal registers, clear the running max and pair index, and go to CMP0 on the next edge.
REQ-015 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-016 The block SHALL ignore input changes after acceptance; all computation SHALL use the latched copies.
REQ-017 Each CMPn state SHALL take exactly one cycle and compute |a-b| as a-b when a>=b, else b-a.
REQ-018 The borrow of the subtract a-b SHALL select the result; the result SHALL be exact in WIDTH bits, with no overflow possible.
REQ-019 Each CMPn state SHALL update the running max and pair index only if the new difference is strictly greater than the stored one, so ties keep the earlier pair.
REQ-020 CMP0 SHALL go to CMP1, CMP1 to CMP2, and CMP2 to DONE unconditionally.
REQ-021 Latency SHALL be fixed: when input is accepted at edge N, out_valid SHALL be 1 after edge N+4.
REQ-022 In DONE, o and o_pair SHALL hold stable while out_ready=0, and the block SHALL stay in DONE indefinitely.
REQ-023 In DONE with out_ready=1, the block SHALL go to IDLE on the next edge, and in_ready SHALL be 1 in the following cycle.
REQ-024 Maximum throughput SHALL be one result per 6 cycles, with no overlap between operand sets.
REQ-025 o and o_pair SHALL retain their last values after leaving DONE until the next CMP0 clears them.
REQ-026 The final o SHALL equal max(x,y,z) minus min(x,y,z).

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL go to IDLE and clear o, o_pair, the running max and the operand registers to 0; out_valid and busy SHALL be 0 and in_ready SHALL be 1 after that edge.
REQ-028 Reset SHALL override every other event, including in_valid or out_ready asserted in the same cycle.
REQ-029 Reset in any state SHALL abort the current operation with no result emitted.
REQ-030 Only clk edges SHALL be sensitive; rst_n changes between edges SHALL have no effect.

Verification
REQ-031 Case: x=3, y=9, z=5, accepted at edge N -> out_valid=1 after edge N+4, with o=6 and o_pair=0.
REQ-032 Case: x=8, y=2, z=14 -> o=12 and o_pair=2, with intermediate max 6 held from CMP0 (CMP1 tie not taken).
REQ-033 Case: x=0, y=15, z=15 -> o=15 and o_pair=0 (tie with x/z resolved to earlier pair); x=y=z=7 -> o=0 and o_pair=0.
REQ-034 Case: out_ready=0 for 3 cycles in DONE -> o, o_pair and out_valid stable, and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-035 Case: rst_n=0 during CMP1 with in_valid=1 -> IDLE, o=0, out_valid=0 and busy=0 after the edge; no result emitted.
REQ-036 Case: x/y/z changed during CMP0..CMP2 -> result reflects the values latched at acceptance.

Source files
------------

// File: rtl/max_diff_seq.sv
// max_diff_seq: sequential maximum pairwise absolute difference of three
// unsigned operands. One comparison per cycle (x/y, x/z, y/z); the result is
// presented with a valid/ready handshake. The result is held until it is
// accepted downstream.
module max_diff_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] o,
   output logic [1:0]       o_pair,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      CMP0,
      CMP1,
      CMP2,
      DONE
   } state_t;

   localparam logic [1:0] PAIR_XY = 2'd0;
   localparam logic [1:0] PAIR_XZ = 2'd1;
   localparam logic [1:0] PAIR_YZ = 2'd2;

   state_t           state;
   logic [WIDTH-1:0] x_q, y_q, z_q;

   // Operand pair under comparison in the current state
   logic [WIDTH-1:0] op_a, op_b;
   logic [1:0]       pair_id;
   logic [WIDTH:0]   sub_ab;
   logic             borrow;
   logic [WIDTH-1:0] diff;
   logic             take;

   // Select the operand pair and form |a-b|, using the borrow of a-b as the selector
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      op_a    = x_q;
      op_b    = y_q;
      pair_id = PAIR_XY;
      unique case (state)
         CMP1:    begin op_a = x_q; op_b = z_q; pair_id = PAIR_XZ; end
         CMP2:    begin op_a = y_q; op_b = z_q; pair_id = PAIR_YZ; end
         default: begin op_a = x_q; op_b = y_q; pair_id = PAIR_XY; end
      endcase
      sub_ab = {1'b0, op_a} - {1'b0, op_b};
      borrow = sub_ab[WIDTH];
      diff   = borrow ? (op_b - op_a) : sub_ab[WIDTH-1:0];
      // Strictly greater: on a tie the earlier pair keeps its place
      take   = (diff > o);
   end

   // Control FSM; o/o_pair double as the running max and its pair index
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         // NOTE: every register, operand copies included, is cleared so an aborted run leaves no trace.
         state     <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         o         <= '0;
         o_pair    <= PAIR_XY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x_q      <= x;
                  y_q      <= y;
                  z_q      <= z;
                  o        <= '0;
                  o_pair   <= PAIR_XY;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CMP0;
               end
            end
            CMP0, CMP1, CMP2: begin
               if (take) begin
                  o      <= diff;
                  o_pair <= pair_id;
               end
               state <= (state == CMP0) ? CMP1 :
                        (state == CMP1) ? CMP2 : DONE;
            end
            DONE: begin
               // First DONE cycle publishes the settled result; then wait for the consumer
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_diff_seq.sv
// tb_max_diff_seq: directed and random operand sets against a reference model
// built from the max-minus-min / first-maximal-pair rule.
module tb_max_diff_seq;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] x, y, z;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] o;
   logic [1:0]       o_pair;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   int checks = 0;
   int errors = 0;

   max_diff_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (x),
      .y         (y),
      .z         (z),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .o         (o),
      .o_pair    (o_pair),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Reference: largest difference and the first pair (in x/y, x/z, y/z order) reaching it
   task automatic model(input int a, input int b, input int c, output int best, output int pair);
      int v[3];
      int d;
      v[0] = a; v[1] = b; v[2] = c;
      best = 0;
      pair = 0;
      for (int p = 0; p < 3; p++) begin
         d = (p == 0) ? absdiff(v[0], v[1]) : (p == 1) ? absdiff(v[0], v[2]) : absdiff(v[1], v[2]);
         if (d > best) begin
            best = d;
            pair = p;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_case(input int a, input int b, input int c, input int hold);
      int best, pair, vmax, vmin;
      model(a, b, c, best, pair);
      vmax = (a > b) ? a : b; vmax = (vmax > c) ? vmax : c;
      vmin = (a < b) ? a : b; vmin = (vmin < c) ? vmin : c;
      chk("model_max_minus_min", best, vmax - vmin);
      chk("in_ready_before", in_ready, 1);
      x = a[WIDTH-1:0]; y = b[WIDTH-1:0]; z = c[WIDTH-1:0];
      in_valid = 1'b1;
      tick();                                  // acceptance edge N
      in_valid = 1'b0;
      x = WIDTH'($urandom); y = WIDTH'($urandom); z = WIDTH'($urandom);
      chk("busy_after_accept", busy, 1);
      chk("in_ready_after_accept", in_ready, 0);
      tick();                                  // N+1
      x = WIDTH'($urandom); y = WIDTH'($urandom); z = WIDTH'($urandom);
      chk("max_after_cmp0", o, absdiff(a, b));
      tick();                                  // N+2
      tick();                                  // N+3
      chk("out_valid_early", out_valid, 0);
      tick();                                  // N+4
      chk("out_valid_latency", out_valid, 1);
      chk("o_result", o, best);
      chk("o_pair_result", o_pair, pair);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_o", o, best);
         chk("hold_o_pair", o_pair, pair);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ret_in_ready", in_ready, 1);
      chk("ret_out_valid", out_valid, 0);
      chk("ret_busy", busy, 0);
      chk("ret_o_retained", o, best);
      chk("ret_pair_retained", o_pair, pair);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; z = '0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_o", o, 0);
      chk("rst_o_pair", o_pair, 0);
      rst_n = 1'b1;

      // Idle without in_valid stays idle
      tick();
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);

      // Directed cases
      run_case(3, 9, 5, 0);
      run_case(8, 2, 14, 3);
      run_case(0, 15, 15, 1);
      run_case(7, 7, 7, 0);
      run_case(15, 0, 0, 0);

      // Reset during CMP1 with in_valid and out_ready high aborts the operation
      x = 4'd1; y = 4'd12; z = 4'd6;
      in_valid = 1'b1;
      tick();                                  // accept -> CMP0
      in_valid = 1'b0;
      tick();                                  // -> CMP1
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_o", o, 0);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_result", out_valid, 0);
      end

      // Random operand sets
      for (int n = 0; n < 24; n++) begin
         run_case(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
